// File: rtl/dmem_ctrl.sv
// Handshaked, byte-addressed little-endian data memory with configurable response
// latency, load extension, alignment/range faults and a post-reset clearing sweep.
module dmem_ctrl #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 256,
    parameter int AW      = 12,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rstn,
    output logic            init_done,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [AW-1:0]   req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int NB        = XLEN / 8;
    localparam int OB        = $clog2(NB);
    localparam int IW        = $clog2(DEPTH);
    localparam int MEM_BYTES = DEPTH * NB;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [XLEN-1:0]   mem_r [DEPTH];
    logic [IW-1:0]     clr_idx_r;
    logic [2:0]        cnt_r;
    logic              we_r;
    logic [1:0]        size_r;
    logic              uns_r;
    logic [AW-1:0]     addr_r;
    logic [XLEN-1:0]   wdata_r;
    logic [XLEN-1:0]   rdata_r;
    logic              err_r;
    logic              ready_r;
    logic              rsp_valid_r;
    logic              init_done_r;

    logic              accept_s;
    logic              fault_s;
    logic              access_s;
    logic [IW-1:0]     widx_s;
    logic [OB-1:0]     ob_s;
    logic [2:0]        align_mask_s;
    logic [NB-1:0]     lanes_s;
    logic [NB-1:0]     be_s;
    logic [AW:0]       end_s;
    logic [XLEN-1:0]   wsh_s;
    logic [XLEN-1:0]   raw_s;

    // Keep the low 8/16/32 bits of a shifted-down word and sign- or zero-extend.
    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw,
                                                 input logic [1:0] size,
                                                 input logic uns);
        logic [XLEN-1:0] mask;
        logic            sgn;
        case (size)
            2'b00:   begin mask = XLEN'(8'hFF);         sgn = raw[7];  end
            2'b01:   begin mask = XLEN'(16'hFFFF);      sgn = raw[15]; end
            2'b10:   begin mask = XLEN'(32'hFFFF_FFFF); sgn = raw[31]; end
            default: begin mask = {XLEN{1'b1}};         sgn = 1'b0;    end
        endcase
        return (raw & mask) | ((sgn & ~uns) ? ~mask : {XLEN{1'b0}});
    endfunction

    assign init_done = init_done_r;
    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;

    assign accept_s = (state_r == IDLE) && req_valid;

    // Decode the latched request: fault check, byte lanes and lane-aligned data.
    always_comb begin
        widx_s = addr_r[OB +: IW];
        ob_s   = addr_r[OB-1:0];
        case (size_r)
            2'b00:   begin align_mask_s = 3'b000; lanes_s = NB'(8'h01); end
            2'b01:   begin align_mask_s = 3'b001; lanes_s = NB'(8'h03); end
            2'b10:   begin align_mask_s = 3'b011; lanes_s = NB'(8'h0F); end
            default: begin align_mask_s = 3'b111; lanes_s = NB'(8'hFF); end
        endcase
        end_s    = {1'b0, addr_r} + ((AW+1)'(1) << size_r);
        fault_s  = ((addr_r[2:0] & align_mask_s) != 3'b000)
                || (end_s > (AW+1)'(MEM_BYTES))
                || ((size_r == 2'b11) && (XLEN == 32));
        be_s     = lanes_s << ob_s;
        wsh_s    = wdata_r << {ob_s, 3'b000};
        raw_s    = mem_r[widx_s] >> {ob_s, 3'b000};
        access_s = (state_r == WAIT) && !fault_s && (cnt_r == 3'd0);
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            CLEAR: begin
                if (clr_idx_r == IW'(DEPTH - 1)) state_nx_s = IDLE;
                else                             state_nx_s = CLEAR;
            end
            IDLE: begin
                if (req_valid) state_nx_s = WAIT;
                else           state_nx_s = IDLE;
            end
            WAIT: begin
                if (fault_s || (cnt_r == 3'd0)) state_nx_s = RESP;
                else                            state_nx_s = WAIT;
            end
            RESP: begin
                if (rsp_ready) state_nx_s = IDLE;
                else           state_nx_s = RESP;
            end
            default: state_nx_s = CLEAR;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_r <= CLEAR;
        else       state_r <= state_nx_s;
    end

    // Storage: the clear sweep and byte-lane stores; no reset on the array itself.
    always_ff @(posedge clk) begin
        if (state_r == CLEAR) begin
            mem_r[clr_idx_r] <= {XLEN{1'b0}};
        end else if (access_s && we_r) begin
            for (int b = 0; b < NB; b++) begin
                if (be_s[b]) mem_r[widx_s][b*8 +: 8] <= wsh_s[b*8 +: 8];
            end
        end
    end

    // Request latch, latency counter, response registers and status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clr_idx_r   <= {IW{1'b0}};
            cnt_r       <= 3'd0;
            we_r        <= 1'b0;
            size_r      <= 2'b00;
            uns_r       <= 1'b0;
            addr_r      <= {AW{1'b0}};
            wdata_r     <= {XLEN{1'b0}};
            rdata_r     <= {XLEN{1'b0}};
            err_r       <= 1'b0;
            ready_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            ready_r     <= (state_nx_s == IDLE);
            rsp_valid_r <= (state_nx_s == RESP);
            init_done_r <= init_done_r | (state_nx_s != CLEAR);
            if (state_r == CLEAR) clr_idx_r <= clr_idx_r + IW'(1);
            if (accept_s) begin
                we_r    <= req_we;
                size_r  <= req_size;
                uns_r   <= req_unsigned;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                cnt_r   <= 3'(LATENCY - 1);
            end
            if (state_r == WAIT) begin
                if (fault_s) begin
                    err_r   <= 1'b1;
                    rdata_r <= {XLEN{1'b0}};
                end else if (cnt_r == 3'd0) begin
                    err_r   <= 1'b0;
                    rdata_r <= we_r ? {XLEN{1'b0}} : load_ext(raw_s, size_r, uns_r);
                end else begin
                    cnt_r <= cnt_r - 3'd1;
                end
            end
            if ((state_r == RESP) && rsp_ready) begin
                rdata_r <= {XLEN{1'b0}};
                err_r   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl (XLEN=32, DEPTH=256, LATENCY=4): directed requests
// push expected responses, an independent monitor pops and compares them.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        init_done;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   n;

    always #5 clk = ~clk;

    dmem_ctrl #(.XLEN(32), .DEPTH(256), .AW(12), .LATENCY(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .init_done    (init_done),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every accepted response is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rstn && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rsp: got rdata %h err %b with nothing outstanding", rsp_rdata, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
            end
        end
    end

    task automatic wait_init(output int cycles);
        cycles = 0;
        while (!init_done && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int t;
        @(negedge clk);
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
            return;
        end
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        exp_q.push_back({exp_rdata, exp_err});
        @(posedge clk);
        #1 req_valid = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_timeout: got no response for addr %h, required one within 50 cycles", addr);
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn         = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 12'h000;
        req_wdata    = 32'h0;
        rsp_ready    = 1'b1;
        #12;
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        wait_init(n);
        check("init_cycles", n, 32'd256);

        // Basic loads/stores and extension.
        do_req(1'b0, 2'b10, 1'b0, 12'h040, 32'h0,        32'h0000_0000, 1'b0);
        do_req(1'b1, 2'b10, 1'b0, 12'h010, 32'h8899AABB, 32'h0000_0000, 1'b0);
        do_req(1'b0, 2'b00, 1'b0, 12'h011, 32'h0,        32'hFFFF_FFAA, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 12'h011, 32'h0,        32'h0000_00AA, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 12'h012, 32'h0,        32'hFFFF_8899, 1'b0);
        do_req(1'b1, 2'b00, 1'b0, 12'h013, 32'h0000005C, 32'h0000_0000, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        32'h5C99_AABB, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 12'h010, 32'h0,        32'hFFFF_AABB, 1'b0);
        do_req(1'b0, 2'b01, 1'b1, 12'h012, 32'h0,        32'h0000_5C99, 1'b0);
        do_req(1'b1, 2'b01, 1'b0, 12'h016, 32'hFFFF7F00, 32'h0000_0000, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 12'h014, 32'h0,        32'h7F00_0000, 1'b0);
        // Top-of-memory boundary.
        do_req(1'b1, 2'b10, 1'b0, 12'h3FC, 32'h12345678, 32'h0000_0000, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 12'h3FF, 32'h0,        32'h0000_0012, 1'b0);
        // Faults: misaligned, out of range, doubleword on a 32-bit memory.
        do_req(1'b0, 2'b01, 1'b0, 12'h001, 32'h0,        32'h0000_0000, 1'b1);
        do_req(1'b1, 2'b10, 1'b0, 12'h002, 32'hDEADBEEF, 32'h0000_0000, 1'b1);
        do_req(1'b0, 2'b10, 1'b0, 12'h3FE, 32'h0,        32'h0000_0000, 1'b1);
        do_req(1'b0, 2'b10, 1'b0, 12'h400, 32'h0,        32'h0000_0000, 1'b1);
        do_req(1'b1, 2'b11, 1'b0, 12'h000, 32'hDEADBEEF, 32'h0000_0000, 1'b1);
        do_req(1'b0, 2'b10, 1'b0, 12'h000, 32'h0,        32'h0000_0000, 1'b0);

        // Latency and backpressure.
        @(negedge clk);
        check("lat_ready", {31'd0, req_ready}, 32'd1);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 12'h010;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        exp_q.push_back({32'h5C99_AABB, 1'b0});
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_rdata", rsp_rdata, 32'h5C99_AABB);
            check("stall_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("ready_before_hs", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_hs", {31'd0, req_ready}, 32'd1);
        check("valid_after_hs", {31'd0, rsp_valid}, 32'd0);
        check("lat_drained", exp_q.size(), 32'd0);

        // Reset in the middle of a store's wait.
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_addr = 12'h020; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        check("mid_rst_init", {31'd0, init_done}, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        wait_init(n);
        check("reinit_cycles", n, 32'd256);
        do_req(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 32'h0000_0000, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'h0000_0000, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised, handshaked data memory for the pipelined core. Replaces the single-cycle combinational-read DM.
- Byte-addressed, little-endian, word-organised storage.
- Accepts one load/store request at a time over a valid/ready channel and returns a response after a configurable latency.
- Adds signed/unsigned load extension, misalignment and range faults, doubleword access when XLEN=64, and a post-reset clearing sweep.

Parameters:
- XLEN, 32, data width in bits; legal values 32 or 64.
- DEPTH, 256, number of XLEN-bit words in storage.
- AW, 12, byte-address width; must satisfy 2^AW >= DEPTH*XLEN/8.
- LATENCY, 1, cycles from request acceptance to response; legal range 1..8.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- init_done  out  1  high once the post-reset clear sweep has finished.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 doubleword.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  AW  byte address.
- req_wdata  in  XLEN  store data, LSB-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  request faulted; no memory side effect.

Behaviour:
- Reset: rstn is asynchronous, active-low.
  - On assertion: state=CLEAR, clear index=0, init_done=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Any in-flight request is discarded; no response is produced for it.
- States: CLEAR, IDLE, WAIT, RESP.
- CLEAR:
  - Zeroes one word per clk, index 0..DEPTH-1.
  - After word DEPTH-1 is written: go to IDLE, set init_done=1. init_done stays 1 until the next reset.
  - req_ready=0 throughout. The sweep takes exactly DEPTH cycles after reset release.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch we, size, unsigned, addr and wdata.
  - Fault check on the latched request. A request faults if any of:
    - addr not a multiple of the access size (2^size bytes);
    - addr + 2^size > DEPTH*XLEN/8;
    - size=11 while XLEN=32.
  - Faulting request: go to RESP next cycle with rsp_err=1, rsp_rdata=0. Memory is untouched.
  - Legal request: load the counter with LATENCY-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0: perform the access and go to RESP.
  - Result: request accepted at edge k gives rsp_valid high after edge k+LATENCY.
- Access rules:
  - Store: write only the addressed bytes. Little-endian: byte i of wdata goes to address addr+i. Other bytes of the word are unchanged.
  - Load: extract the addressed bytes, then sign- or zero-extend to XLEN.
  - Doubleword with XLEN=64: the full word, no extension.
  - Word with XLEN=32: no extension; req_unsigned is ignored.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_err held stable until rsp_valid&rsp_ready.
  - On that handshake: go to IDLE, clear rsp_rdata and rsp_err to 0.
  - rsp_valid may stay high indefinitely under backpressure.
- Ordering and concurrency:
  - req_ready=0 in WAIT and RESP; exactly one request is outstanding at a time.
  - A load accepted after a store's response has completed observes that store's data.
- Storage is not readable through any other path. rsp_rdata is registered, never combinational from req_addr.

Test Plan:
- Reset, then idle with DEPTH=256 → init_done rises exactly 256 cycles after rstn release. A word load at 0x40 → rsp_rdata=0, rsp_err=0.
- Store word 0x8899AABB at 0x10. Load byte 0x11 signed → 0xFFFFFFAA. Load byte 0x11 unsigned → 0x000000AA. Load half 0x12 signed → 0xFFFF8899.
- Store byte 0x5C at 0x13 over the 0x10 word above, then load word 0x10 → 0x5C99AABB.
- Half load at 0x01, word store at 0x02, and word load at 0x3FE (DEPTH=256, XLEN=32) → each gives rsp_err=1, rsp_rdata=0. A follow-up load of word 0x00 shows no modification.
- LATENCY=4 with rsp_ready held 0 for 10 cycles:
  - rsp_valid rises 4 cycles after acceptance; data stays stable during the stall.
  - req_ready stays 0 until the cycle after the rsp_ready handshake.
- Assert rstn low during WAIT of a store to 0x20 → no response is emitted and the CLEAR sweep restarts. Load of 0x20 after init_done=1 → 0.
